// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline.
// Resolves load-use, branch squash, memory wait and halt drain.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT  = 16,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        halt_req,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        idex_we,
  output logic        exmem_we,
  output logic        memwb_we,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        memwb_flush,
  output logic        mem_error,
  output logic        halted,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  typedef enum logic [1:0] {
    RUN, MEM_WAIT, DRAIN, HALTED
  } state_t;

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic [DW-1:0] drain_cnt;

  logic       mem_stall;
  logic       load_use;
  logic       active;
  logic       br_hit;
  logic       lu_hit;
  logic [4:0] we_c;
  logic [3:0] fl_c;

  assign mem_stall = mem_req & ~mem_ready;
  assign load_use  = ex_is_load & (ex_rd != 5'd0) &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) |
                      (id_use_rs2 & (id_rs2 == ex_rd)));
  assign active    = (state == RUN) | (state == MEM_WAIT);
  assign br_hit    = ~mem_stall & ex_branch_taken;
  assign lu_hit    = ~mem_stall & ~ex_branch_taken & load_use;

  // we_c = {pc, ifid, idex, exmem, memwb}; fl_c = {ifid, idex, exmem, memwb}
  always_comb begin
    we_c = 5'b11111;
    fl_c = 4'b0000;
    unique case (state)
      RUN, MEM_WAIT: begin
        unique case (1'b1)
          mem_stall: begin
            we_c = 5'b00001;
            fl_c = 4'b0001;
          end
          br_hit: fl_c = 4'b1100;
          lu_hit: begin
            we_c = 5'b00111;
            fl_c = 4'b0100;
          end
          default: ;
        endcase
      end
      DRAIN: begin
        if (mem_stall) begin
          we_c = 5'b00001;
          fl_c = 4'b0001;
        end else begin
          we_c = 5'b01111;
          fl_c = 4'b1000;
        end
      end
      HALTED: we_c = 5'b00000;
      default: ;
    endcase
  end

  assign {pc_we, ifid_we, idex_we, exmem_we, memwb_we} =
    we_c & {5{Rst_n}};
  assign {ifid_flush, idex_flush, exmem_flush, memwb_flush} =
    fl_c & {4{Rst_n}};
  assign halted = (state == HALTED);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state       <= RUN;
      wait_cnt    <= '0;
      drain_cnt   <= '0;
      mem_error   <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (active && !we_c[4] && stall_count != 32'hFFFF_FFFF)
        stall_count <= stall_count + 32'd1;
      if (active && br_hit && flush_count != 32'hFFFF_FFFF)
        flush_count <= flush_count + 32'd1;
      unique case (state)
        RUN: begin
          if (mem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= WW'(1);
          end else if (halt_req) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (!mem_stall) begin
            state <= RUN;
          end else if (wait_cnt == WW'(MEM_TIMEOUT - 1)) begin
            state     <= HALTED;
            mem_error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        DRAIN: begin
          if (!mem_stall) begin
            if (drain_cnt == DW'(DRAIN_CYCLES - 1))
              state <= HALTED;
            else
              drain_cnt <= drain_cnt + DW'(1);
          end
        end
        HALTED: ;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl.
// Reference model predicts controls and counters each cycle.
module tb_pipeline_hazard_ctrl;

  logic        Clk;
  logic        Rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2;
  logic        ex_is_load, ex_branch_taken;
  logic        mem_req, mem_ready, halt_req;
  logic        pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic        mem_error, halted;
  logic [31:0] stall_count, flush_count;

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT(16),
    .DRAIN_CYCLES(4)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .halt_req(halt_req),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we),
    .exmem_we(exmem_we), .memwb_we(memwb_we),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .mem_error(mem_error), .halted(halted),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  logic [8:0] sb[$];

  // model state: 0 RUN, 1 MEM_WAIT, 2 DRAIN, 3 HALTED
  int          m_st;
  int          m_wait;
  int          m_drain;
  logic        m_err;
  logic [31:0] m_stall, m_flush;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic mreset();
    m_st = 0; m_wait = 0; m_drain = 0;
    m_err = 1'b0; m_stall = '0; m_flush = '0;
  endtask

  function automatic logic [8:0] model_ctl();
    logic ms, lu;
    logic pc, fi, di, ei, wi, ff, fd, fe, fw;
    ms = mem_req & ~mem_ready;
    lu = ex_is_load && ex_rd != 0 &&
         ((id_use_rs1 && id_rs1 == ex_rd) ||
          (id_use_rs2 && id_rs2 == ex_rd));
    pc = 1; fi = 1; di = 1; ei = 1; wi = 1;
    ff = 0; fd = 0; fe = 0; fw = 0;
    if (m_st == 3) begin
      pc = 0; fi = 0; di = 0; ei = 0; wi = 0;
    end else if (ms) begin
      pc = 0; fi = 0; di = 0; ei = 0; fw = 1;
    end else if (m_st == 2) begin
      pc = 0; ff = 1;
    end else if (ex_branch_taken) begin
      ff = 1; fd = 1;
    end else if (lu) begin
      pc = 0; fi = 0; fd = 1;
    end
    return {pc, fi, di, ei, wi, ff, fd, fe, fw};
  endfunction

  task automatic model_seq(input logic [8:0] ctl);
    logic ms;
    ms = mem_req & ~mem_ready;
    if (m_st <= 1) begin
      if (!ctl[8] && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (!ms && ex_branch_taken && m_flush != 32'hFFFF_FFFF)
        m_flush++;
    end
    case (m_st)
      0: if (ms) begin m_st = 1; m_wait = 1; end
         else if (halt_req) begin m_st = 2; m_drain = 0; end
      1: if (!ms) m_st = 0;
         else if (m_wait + 1 == 16) begin m_st = 3; m_err = 1; end
         else m_wait++;
      2: if (!ms) begin
           if (m_drain + 1 == 4) m_st = 3;
           else m_drain++;
         end
      default: ;
    endcase
  endtask

  function automatic logic [8:0] dut_ctl();
    return {pc_we, ifid_we, idex_we, exmem_we, memwb_we,
            ifid_flush, idex_flush, exmem_flush, memwb_flush};
  endfunction

  task automatic cyc(input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2,
                     input logic [4:0] rd, input logic ld,
                     input logic br, input logic mrq,
                     input logic mrd, input logic hr);
    logic [8:0] e;
    @(negedge Clk);
    id_rs1 = rs1; id_rs2 = rs2;
    id_use_rs1 = u1; id_use_rs2 = u2;
    ex_rd = rd; ex_is_load = ld; ex_branch_taken = br;
    mem_req = mrq; mem_ready = mrd; halt_req = hr;
    e = model_ctl();
    sb.push_back(e);
    #1;
    chk("ctl", {23'd0, dut_ctl()}, {23'd0, sb.pop_front()});
    model_seq(e);
    @(posedge Clk);
    #1;
    chk("stall_count", stall_count, m_stall);
    chk("flush_count", flush_count, m_flush);
    chk("halted", {31'd0, halted}, {31'd0, m_st == 3});
    chk("mem_error", {31'd0, mem_error}, {31'd0, m_err});
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic reset_pulse();
    @(negedge Clk);
    Rst_n = 1'b0;
    sb.push_back(9'd0);
    #1;
    chk("rst_ctl", {23'd0, dut_ctl()}, {23'd0, sb.pop_front()});
    chk("rst_stall", stall_count, 32'd0);
    chk("rst_flush", flush_count, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_err", {31'd0, mem_error}, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    mem_req = 0; mem_ready = 0; halt_req = 0;
    ex_branch_taken = 0; ex_is_load = 0;
    mreset();
  endtask

  initial begin
    Rst_n = 1'b0;
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = 0; ex_is_load = 0; ex_branch_taken = 0;
    mem_req = 0; mem_ready = 0; halt_req = 0;
    mreset();
    reset_pulse();
    idle();
    chk("first_we", {23'd0, dut_ctl()}, {23'd0, 9'b111110000});

    // load x5 in EX, ID reads x5 through rs2
    cyc(1, 5, 1, 1, 5, 1, 0, 0, 0, 0);
    idle();
    chk("lu_stall", stall_count, 32'd1);
    // x0 never hazards
    cyc(0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    // branch wins over load-use
    cyc(7, 3, 1, 0, 7, 1, 1, 0, 0, 0);
    chk("br_flush", flush_count, 32'd1);
    chk("br_stall", stall_count, 32'd1);

    // 3-cycle memory wait with a branch that must be ignored
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    chk("mw_stall", stall_count, 32'd4);
    chk("mw_flush", flush_count, 32'd1);

    // halt: 4 drain cycles then halted; branch ignored afterwards
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (4) idle();
    chk("drain_halted", {31'd0, halted}, 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("halt_noflush", flush_count, 32'd1);
    chk("halt_stall", stall_count, 32'd4);

    // reset pulsed mid-wait
    reset_pulse();
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    reset_pulse();
    idle();
    chk("post_rst", stall_count, 32'd0);

    // memory timeout
    repeat (16) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("to_err", {31'd0, mem_error}, 32'd1);
    chk("to_halted", {31'd0, halted}, 32'd1);
    chk("to_stall", stall_count, 32'd16);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    chk("to_ctl", {23'd0, dut_ctl()}, 32'd0);

    // random mix against the model
    reset_pulse();
    for (int i = 0; i < 80; i++) begin
      cyc(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 1)), ($urandom_range(0, 24) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
